gmii_tx_framer: RTL
===================

# gmii_tx_framer

Byte-wide Ethernet transmit framer that converts an AXI-stream frame into GMII transmit signalling for the PHY: preamble/SFD insertion, payload transfer, optional minimum-length padding, CRC-32 FCS append and inter-frame gap enforcement. It sits directly upstream of the GMII PHY pins and drives txd/tx_en/tx_er synchronously to the transmit clock. Mid-frame underflow and upstream-flagged bad frames are reported to the PHY with tx_er.

## Interface
- IFG_CYCLES, 12: minimum idle cycles with tx_en low between frames; legal range 1–255.
- MIN_FRAME_LEN, 60: payload+pad length, excluding FCS, enforced when padding is compiled in.
- clk  in  1  transmit clock (125 MHz GMII); all logic is on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  8  payload byte (destination MAC first).
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  byte accepted when tvalid && tready.
- s_axis_tlast  in  1  last payload byte of frame.
- s_axis_tuser  in  1  sampled with tlast; 1 = frame is bad.
- gmii_txd  out  8  GMII transmit data, registered.
- gmii_tx_en  out  1  GMII transmit enable, registered.
- gmii_tx_er  out  1  GMII transmit error, registered.
- start_packet  out  1  one-cycle pulse in the cycle the first preamble byte is driven.
- error_underflow  out  1  one-cycle pulse when underflow is detected.

## Operation
- States: IDLE, PREAMBLE, PAYLOAD, PAD, FCS, DRAIN, IFG.
- IDLE: tready=0. When tvalid=1, go to PREAMBLE. The byte is not consumed.
- PREAMBLE: drives 7 bytes of 0x55, then 1 byte of 0xD5 (SFD), with tx_en=1 and tready=0. tready rises in the SFD cycle so that the first byte is accepted then.
- PAYLOAD: tready=1. Each accepted byte is driven on txd the next cycle with tx_en=1 and is folded into the CRC.
  - Byte counter: 16 bits, saturating.
  - tlast accepted: go to PAD if count < MIN_FRAME_LEN and padding is enabled; otherwise go to FCS.
- Underflow: tvalid=0 in any PAYLOAD cycle (tready is high throughout PAYLOAD).
  - Drive txd=0x00, tx_en=1, tx_er=1 for one cycle.
  - Pulse error_underflow.
  - Go to DRAIN. No FCS is sent for this frame.
- DRAIN: tready=1, tx_en=0. Bytes are discarded until tlast is accepted, then go to IFG.
- PAD: drives 0x00 bytes, CRC-folded, until count = MIN_FRAME_LEN, then go to FCS.
- FCS: 4 bytes, CRC-32, least-significant byte first.
  - Reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, final value complemented.
  - CRC covers the payload and pad only; it excludes preamble and SFD.
  - If tuser=1 was captured with tlast, all 4 FCS cycles also drive tx_er=1.
- IFG: tx_en=0, tx_er=0, txd=0x00 for IFG_CYCLES cycles (8-bit counter), then go to IDLE.
- Reset values:
  - State: IDLE.
  - Outputs: txd=0x00, tx_en=0, tx_er=0, tready=0, start_packet=0, error_underflow=0.
  - CRC register: 0xFFFFFFFF. Counters: 0.
- Reset mid-frame: outputs drop immediately (asynchronous). The partial frame is abandoned and the upstream source is responsible for flushing it. The next frame after reset release starts with a full preamble and no IFG.

## Timing
- tvalid rises in IDLE at cycle N. Then:
  - tx_en=1 with 0x55 from N+1.
  - SFD at N+8.
  - First payload byte on txd at N+9.
- Payload pipeline latency is 1 cycle (accept to txd). There are no bubbles while tvalid is held.
- Last FCS byte at cycle L. The earliest next preamble byte is at L+IFG_CYCLES+2 (IFG cycles, then 1 IDLE cycle, then the PREAMBLE register stage).
- Frame length on the wire = 8 + max(payload, MIN_FRAME_LEN when padding is enabled) + 4 cycles.

## Configuration
- GMII_TX_FRAMER_PAD_EN defined:
  - PAD state is compiled in.
  - Short frames are zero-padded to MIN_FRAME_LEN before the FCS.
- Not defined:
  - PAD state and the MIN_FRAME_LEN comparison are removed.
  - FCS directly follows the last payload byte regardless of length.
  - The byte counter may be removed.

## Structure
- Shared package (eth_pkg) holds:
  - State enum.
  - Constants ETH_PREAMBLE (0x55), ETH_SFD (0xD5), ETH_CRC_POLY (0xEDB88320), ETH_CRC_INIT (0xFFFFFFFF).
- Sub-module eth_crc32_byte: combinational next-CRC from (crc_in[31:0], data[7:0]). It is reused by the receive checker.

## Test plan
- Send ASCII payload "123456789" (9 bytes) with padding disabled. Expect:
  - 7×0x55, then 0xD5.
  - Payload bytes.
  - FCS bytes 0x26, 0x39, 0xF4, 0xCB.
  - tx_er=0 throughout.
- Send the same 9-byte frame with GMII_TX_FRAMER_PAD_EN. Expect:
  - 9 payload bytes, then 51×0x00.
  - 4 FCS bytes computed over 60 bytes.
  - 72 tx_en cycles in total.
- Send two back-to-back 64-byte frames with tvalid held high and IFG_CYCLES=12. Expect exactly 12 tx_en=0 cycles plus 1 IDLE cycle between the last FCS byte and the next 0x55.
- Drop tvalid for 1 cycle after payload byte 20. Expect:
  - One byte driven with tx_er=1.
  - error_underflow pulses once.
  - No FCS is sent.
  - Remaining bytes are drained until tlast, followed by the IFG.
- Send tlast with tuser=1 on a 64-byte frame. Expect tx_er=1 on exactly the 4 FCS cycles.
- Assert rst during payload byte 30. Expect:
  - tx_en=0 and tready=0 asynchronously.
  - After release, a new frame produces a full preamble and a correct FCS.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: transmit state encoding, framing constants and
// the reflected CRC-32 byte step used by the transmit framer and receive checker.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_PAYLOAD  = 3'd2,
    ST_PAD      = 3'd3,
    ST_FCS      = 3'd4,
    ST_DRAIN    = 3'd5,
    ST_IFG      = 3'd6
  } tx_state_e;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT = 32'hFFFFFFFF;

  function automatic logic [31:0] eth_crc32_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ ETH_CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  // FCS goes out complemented, least-significant byte first.
  function automatic logic [7:0] eth_fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [31:0] inv;
    inv = ~crc;
    case (idx)
      2'd0:    return inv[7:0];
      2'd1:    return inv[15:8];
      2'd2:    return inv[23:16];
      default: return inv[31:24];
    endcase
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational next-CRC for one byte of Ethernet CRC-32 (reflected form).
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  assign crc_out = eth_crc32_step(crc_in, data);

endmodule

// File: rtl/gmii_tx_framer.sv
// AXI-stream to GMII transmit framer: preamble/SFD, payload, optional padding,
// CRC-32 FCS and inter-frame gap. Define GMII_TX_FRAMER_PAD_EN to compile in padding.
module gmii_tx_framer
  import eth_pkg::*;
#(
  parameter int IFG_CYCLES    = 12,
  parameter int MIN_FRAME_LEN = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       start_packet,
  output logic       error_underflow
);

  localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES);

  tx_state_e   state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [31:0] crc_r, crc_s, crc_next_s;
  logic [7:0]  crc_data_s;
  logic        bad_r, bad_s;
  logic [7:0]  txd_s;
  logic        tx_en_s, tx_er_s, tready_s, start_s, ufl_s;

`ifdef GMII_TX_FRAMER_PAD_EN
  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);
  logic [15:0] len_r, len_s, len_inc_s;

  assign len_inc_s = (len_r == 16'hFFFF) ? len_r : (len_r + 16'd1);
`endif

  // Pad cycles fold zero bytes; only PAYLOAD folds the stream byte.
  assign crc_data_s = (state_r == ST_PAYLOAD) ? s_axis_tdata : 8'h00;

  eth_crc32_byte u_crc (
    .crc_in  (crc_r),
    .data    (crc_data_s),
    .crc_out (crc_next_s)
  );

  // Next-state and next-output decode; outputs are registered one cycle later.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    crc_s    = crc_r;
    bad_s    = bad_r;
    txd_s    = 8'h00;
    tx_en_s  = 1'b0;
    tx_er_s  = 1'b0;
    start_s  = 1'b0;
    ufl_s    = 1'b0;
`ifdef GMII_TX_FRAMER_PAD_EN
    len_s    = len_r;
`endif
    case (state_r)
      ST_IDLE: begin
        cnt_s = 8'd0;
        crc_s = ETH_CRC_INIT;
        bad_s = 1'b0;
`ifdef GMII_TX_FRAMER_PAD_EN
        len_s = 16'd0;
`endif
        if (s_axis_tvalid) begin
          state_s = ST_PREAMBLE;
          txd_s   = ETH_PREAMBLE;
          tx_en_s = 1'b1;
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        tx_en_s = 1'b1;
        if (cnt_r == 8'd6) begin
          txd_s   = ETH_SFD;
          cnt_s   = 8'd0;
          state_s = ST_PAYLOAD;
        end else begin
          txd_s   = ETH_PREAMBLE;
          cnt_s   = cnt_r + 8'd1;
        end
      end
      ST_PAYLOAD: begin
        tx_en_s = 1'b1;
        if (s_axis_tvalid) begin
          txd_s = s_axis_tdata;
          crc_s = crc_next_s;
`ifdef GMII_TX_FRAMER_PAD_EN
          len_s = len_inc_s;
`endif
          if (s_axis_tlast) begin
            bad_s = s_axis_tuser;
`ifdef GMII_TX_FRAMER_PAD_EN
            if (len_inc_s < MIN_LEN) begin
              state_s = ST_PAD;
            end else begin
              state_s = ST_FCS;
            end
`else
            state_s = ST_FCS;
`endif
          end else begin
            state_s = ST_PAYLOAD;
          end
        end else begin
          tx_er_s = 1'b1;
          ufl_s   = 1'b1;
          state_s = ST_DRAIN;
        end
      end
`ifdef GMII_TX_FRAMER_PAD_EN
      ST_PAD: begin
        tx_en_s = 1'b1;
        crc_s   = crc_next_s;
        len_s   = len_inc_s;
        if (len_inc_s >= MIN_LEN) begin
          state_s = ST_FCS;
        end else begin
          state_s = ST_PAD;
        end
      end
`endif
      ST_FCS: begin
        tx_en_s = 1'b1;
        tx_er_s = bad_r;
        txd_s   = eth_fcs_byte(crc_r, cnt_r[1:0]);
        if (cnt_r[1:0] == 2'd3) begin
          cnt_s   = 8'd0;
          state_s = ST_IFG;
        end else begin
          cnt_s   = cnt_r + 8'd1;
        end
      end
      ST_DRAIN: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          cnt_s   = 8'd0;
          state_s = ST_IFG;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      // The first IFG cycle overlaps the last FCS byte still held in the output register.
      ST_IFG: begin
        if (cnt_r == IFG_LAST) begin
          cnt_s   = 8'd0;
          state_s = ST_IDLE;
        end else begin
          cnt_s   = cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    tready_s = (state_s == ST_PAYLOAD) || (state_s == ST_DRAIN);
  end

  // State, CRC and registered GMII/stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      cnt_r           <= 8'd0;
      crc_r           <= ETH_CRC_INIT;
      bad_r           <= 1'b0;
      gmii_txd        <= 8'h00;
      gmii_tx_en      <= 1'b0;
      gmii_tx_er      <= 1'b0;
      s_axis_tready   <= 1'b0;
      start_packet    <= 1'b0;
      error_underflow <= 1'b0;
    end else begin
      state_r         <= state_s;
      cnt_r           <= cnt_s;
      crc_r           <= crc_s;
      bad_r           <= bad_s;
      gmii_txd        <= txd_s;
      gmii_tx_en      <= tx_en_s;
      gmii_tx_er      <= tx_er_s;
      s_axis_tready   <= tready_s;
      start_packet    <= start_s;
      error_underflow <= ufl_s;
    end
  end

`ifdef GMII_TX_FRAMER_PAD_EN
  // Saturating frame byte counter for minimum-length padding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r <= 16'd0;
    end else begin
      len_r <= len_s;
    end
  end
`endif

endmodule
